// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider using a restoring shift-subtract core.
// Produces one quotient bit per clock and saturates results that do not fit the Q format.
module fixed_point_div #(
  parameter int INTEGER_PART_WIDTH    = 3,
  parameter int FRACTIONAL_PART_WIDTH = 2,
  localparam int NUMBER_WIDTH   = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int DIVIDEND_WIDTH = NUMBER_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUMBER_WIDTH-1:0] a,
  input  logic [NUMBER_WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [NUMBER_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    div_by_zero
);

  localparam int NW = NUMBER_WIDTH;
  localparam int DW = DIVIDEND_WIDTH;
  localparam int CW = $clog2(DW + 1);

  localparam logic [NW-1:0] MAX_POS   = {1'b0, {(NW-1){1'b1}}};
  localparam logic [NW-1:0] MIN_NEG   = {1'b1, {(NW-1){1'b0}}};
  localparam logic [DW-1:0] Q_POS_LIM = DW'(MAX_POS);
  localparam logic [DW-1:0] Q_NEG_LIM = DW'(MAX_POS) + DW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_dvd;
  logic [NW-1:0]   r_dvs;
  logic [NW-1:0]   r_rem;
  logic [DW-1:0]   r_quo;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_a_neg;
  logic            r_b_zero;
  logic            r_busy;
  logic            r_done;
  logic [NW-1:0]   r_result;
  logic            r_overflow;
  logic            r_div_by_zero;

  logic [NW-1:0]   w_a_mag;
  logic [NW-1:0]   w_b_mag;
  logic [NW:0]     w_rem_shift;
  logic [NW:0]     w_rem_sub;
  logic            w_fits;
  logic [NW-1:0]   w_result;
  logic            w_overflow;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(NW-1).
  assign w_a_mag     = a[NW-1] ? (~a + 1'b1) : a;
  assign w_b_mag     = b[NW-1] ? (~b + 1'b1) : b;
  assign w_rem_shift = {r_rem, r_dvd[DW-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_dvs};
  assign w_fits      = (w_rem_shift >= {1'b0, r_dvs});

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    if (r_b_zero) begin
      w_result = r_a_neg ? MIN_NEG : MAX_POS;
    end else if (!r_neg) begin
      if (r_quo > Q_POS_LIM) begin
        w_result   = MAX_POS;
        w_overflow = 1'b1;
      end else begin
        w_result = r_quo[NW-1:0];
      end
    end else if (r_quo > Q_NEG_LIM) begin
      w_result   = MIN_NEG;
      w_overflow = 1'b1;
    end else begin
      w_result = ~r_quo[NW-1:0] + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_cnt         <= '0;
      r_neg         <= 1'b0;
      r_a_neg       <= 1'b0;
      r_b_zero      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_neg    <= a[NW-1] ^ b[NW-1];
            r_a_neg  <= a[NW-1];
            r_b_zero <= (b == '0);
            r_dvd    <= DW'(w_a_mag) << FRACTIONAL_PART_WIDTH;
            r_dvs    <= w_b_mag;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= CW'(DW);
            r_busy   <= 1'b1;
            r_state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_dvd <= r_dvd << 1;
          r_rem <= w_fits ? w_rem_sub[NW-1:0] : w_rem_shift[NW-1:0];
          r_quo <= {r_quo[DW-2:0], w_fits};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_result      <= w_result;
          r_overflow    <= w_overflow;
          r_div_by_zero <= r_b_zero;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_fixed_point_div.sv
// Self-checking bench for fixed_point_div: directed, exhaustive and random operands
// against a plain-arithmetic reference model, plus handshake and reset scenarios.
module tb_fixed_point_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start0, start1;
  logic [6:0]        a_in, b_in;
  logic              busy0, done0, ov0, dz0;
  logic signed [4:0] res0;
  logic              busy1, done1, ov1, dz1;
  logic signed [6:0] res1;

  int checks = 0;
  int errors = 0;

  fixed_point_div #(.INTEGER_PART_WIDTH(3), .FRACTIONAL_PART_WIDTH(2)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .a(a_in[4:0]), .b(b_in[4:0]),
    .busy(busy0), .done(done0), .result(res0), .overflow(ov0), .div_by_zero(dz0)
  );

  fixed_point_div #(.INTEGER_PART_WIDTH(4), .FRACTIONAL_PART_WIDTH(3)) u_wide (
    .clk(clk), .rst(rst), .start(start1), .a(a_in), .b(b_in),
    .busy(busy1), .done(done1), .result(res1), .overflow(ov1), .div_by_zero(dz1)
  );

  // Reference: real-valued a/b scaled to the Q format, truncated toward zero, then saturated.
  function automatic void model(input int a, input int b, input int ib, input int fb,
                                output int r, output bit ov, output bit dz);
    int maxp = (1 << (ib + fb - 1)) - 1;
    int minn = -(1 << (ib + fb - 1));
    int q;
    ov = 1'b0;
    dz = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      r  = (a >= 0) ? maxp : minn;
    end else begin
      q = ((a < 0 ? -a : a) * (1 << fb)) / (b < 0 ? -b : b);
      if ((a < 0) != (b < 0)) begin
        if (q > -minn) begin r = minn; ov = 1'b1; end
        else r = -q;
      end else begin
        if (q > maxp) begin r = maxp; ov = 1'b1; end
        else r = q;
      end
    end
  endfunction

  function automatic int exp_lat(input bit w);
    return w ? 11 : 8;
  endfunction

  function automatic bit cur_done(input bit w);
    return w ? done1 : done0;
  endfunction

  function automatic bit cur_busy(input bit w);
    return w ? busy1 : busy0;
  endfunction

  // Runs one operation from the negedge before the start edge; returns in the done cycle.
  task automatic do_op(input bit w, input int a, input int b, output int r, output bit ov,
                       output bit dz, output int lat, output int busy_cyc);
    @(negedge clk);
    a_in = 7'(a);
    b_in = 7'(b);
    if (w) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0   = 1'b0;
    start1   = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (!cur_done(w) && lat < 40) begin
      if (cur_busy(w)) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    r  = w ? int'(res1) : int'(res0);
    ov = w ? ov1 : ov0;
    dz = w ? dz1 : dz0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, ov0, dz0, res0} !== 9'd0) begin
      errors++;
      $display("FAIL reset_narrow got %b expected 0", {busy0, done0, ov0, dz0, res0});
    end
    checks++;
    if ({busy1, done1, ov1, dz1, res1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_wide got %b expected 0", {busy1, done1, ov1, dz1, res1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int ta [8] = '{6, -12, 4, 12, -16, -16, -4, 0};
    int tb [8] = '{2,   8, -12, 1,   1,  -4,  0, 0};
    int tr [8] = '{12, -6, -1, 15, -16,  15, -16, 15};
    bit tov[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    bit tdz[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int r, lat, bc;
    bit ov, dz;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, ta[i], tb[i], r, ov, dz, lat, bc);
      checks++;
      if (r !== tr[i] || ov !== tov[i] || dz !== tdz[i]) begin
        errors++;
        $display("FAIL directed a=%0d b=%0d got r=%0d ov=%0d dz=%0d expected r=%0d ov=%0d dz=%0d",
                 ta[i], tb[i], r, ov, dz, tr[i], tov[i], tdz[i]);
      end
      checks++;
      if (lat !== 8 || bc !== 8) begin
        errors++;
        $display("FAIL directed_latency a=%0d b=%0d got lat=%0d busy=%0d expected 8/8",
                 ta[i], tb[i], lat, bc);
      end
    end
  endtask

  task automatic test_exhaustive();
    int r, er, lat, bc;
    bit ov, dz, eov, edz;
    for (int ai = -16; ai < 16; ai++) begin
      for (int bi = -16; bi < 16; bi++) begin
        do_op(1'b0, ai, bi, r, ov, dz, lat, bc);
        model(ai, bi, 3, 2, er, eov, edz);
        checks++;
        if (r !== er || ov !== eov || dz !== edz || lat !== 8) begin
          errors++;
          $display("FAIL exhaustive a=%0d b=%0d got r=%0d ov=%0d dz=%0d lat=%0d expected r=%0d ov=%0d dz=%0d lat=8",
                   ai, bi, r, ov, dz, lat, er, eov, edz);
        end
      end
    end
  endtask

  task automatic test_random_wide();
    int a, b, r, er, lat, bc;
    bit ov, dz, eov, edz;
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 127)) - 64;
      b = (i % 10 == 0) ? 0 : int'($urandom_range(0, 127)) - 64;
      do_op(1'b1, a, b, r, ov, dz, lat, bc);
      model(a, b, 4, 3, er, eov, edz);
      checks++;
      if (r !== er || ov !== eov || dz !== edz || lat !== exp_lat(1'b1)) begin
        errors++;
        $display("FAIL random_wide a=%0d b=%0d got r=%0d ov=%0d dz=%0d lat=%0d expected r=%0d ov=%0d dz=%0d lat=%0d",
                 a, b, r, ov, dz, lat, er, eov, edz, exp_lat(1'b1));
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit extra;
    @(negedge clk);
    a_in = 7'd6; b_in = 7'd2; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 40) begin
      if (lat == 3) begin
        a_in = 7'(-16); b_in = 7'd1; start0 = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start0 = 1'b0;
    checks++;
    if (int'(res0) !== 12 || ov0 !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL start_while_busy got r=%0d ov=%0d lat=%0d expected r=12 ov=0 lat=8",
               res0, ov0, lat);
    end
    extra = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0 || busy0) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy_phantom got activity=%0d expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int r, lat, bc;
    bit ov, dz, held_bad, busy_first;
    do_op(1'b0, 6, 2, r, ov, dz, lat, bc);
    // Still inside the done cycle: this start is sampled on the very next edge.
    a_in = 7'(-12); b_in = 7'd8; start0 = 1'b1;
    @(posedge clk); #1;
    start0     = 1'b0;
    busy_first = busy0;
    held_bad   = 1'b0;
    lat        = 0;
    while (!done0 && lat < 40) begin
      if (int'(res0) !== 12) held_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (busy_first !== 1'b1 || held_bad !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_hold got busy=%0d held_bad=%0d expected busy=1 held_bad=0",
               busy_first, held_bad);
    end
    checks++;
    if (int'(res0) !== -6 || lat !== 8) begin
      errors++;
      $display("FAIL back_to_back got r=%0d lat=%0d expected r=-6 lat=8", res0, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    int r, lat, bc;
    bit ov, dz, extra;
    do_op(1'b0, 12, 1, r, ov, dz, lat, bc);
    @(negedge clk);
    a_in = 7'(-12); b_in = 7'd8; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy0, done0, ov0, dz0, res0} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_op got %b expected 0", {busy0, done0, ov0, dz0, res0});
    end
    extra = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0 || busy0) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op_no_done got activity=%0d expected 0", extra);
    end
    do_op(1'b0, 6, 2, r, ov, dz, lat, bc);
    checks++;
    if (r !== 12 || ov !== 1'b0 || dz !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL reset_mid_op_recover got r=%0d ov=%0d dz=%0d lat=%0d expected 12/0/0/8",
               r, ov, dz, lat);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    a_in   = '0;
    b_in   = '0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_random_wide();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
